// File: rtl/serial_add32_ctrl_if.sv
// serial_add32_ctrl_if
// Bundles the request and result signals of the nibble-serial adder/subtractor.
//   start  : request pulse, sampled on every rising edge
//   op     : 0 = add (a+b), 1 = subtract (a-b)
//   a, b   : operands, latched only when a start is accepted
//   busy   : high while nibbles are being processed
//   done   : one-cycle pulse, result valid
//   result : sum/difference, held from done until the next accepted start
//   co     : carry out of the MSB nibble (subtract: 1 = no borrow)
//   ov     : signed overflow
//   zero   : result equals 0
// The master modport is the requester side; the slave modport is the adder.
interface serial_add32_ctrl_if #(
    parameter int NIB = 8
);
    logic              start;
    logic              op;
    logic [4*NIB-1:0]  a;
    logic [4*NIB-1:0]  b;
    logic              busy;
    logic              done;
    logic [4*NIB-1:0]  result;
    logic              co;
    logic              ov;
    logic              zero;

    modport master (
        output start,
        output op,
        output a,
        output b,
        input  busy,
        input  done,
        input  result,
        input  co,
        input  ov,
        input  zero
    );

    modport slave (
        input  start,
        input  op,
        input  a,
        input  b,
        output busy,
        output done,
        output result,
        output co,
        output ov,
        output zero
    );
endinterface

// File: rtl/serial_add32_ctrl.sv
// serial_add32_ctrl
// Nibble-serial adder/subtractor: a single 4-bit carry-lookahead slice
// (cla4_ov) is reused for NIB cycles, LSB nibble first.  Subtraction is done
// as a + ~b + 1 by inverting b at latch time and seeding the carry with 1.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : serial_add32_ctrl_if slave modport (start/op/a/b in,
//           busy/done/result/co/ov/zero out)
// Latency: start accepted at edge k -> done high in the cycle after edge k+NIB.

// 4-bit carry-lookahead slice.  c3 is the carry into bit 3, exported so the
// caller can form signed overflow as c3 ^ co.
module cla4_ov (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = x & y;
    assign p = x ^ y;

    // Fully expanded lookahead terms: every carry depends only on g, p, ci.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[3:0];
    assign co = c[4];
    assign c3 = c[3];
endmodule

module serial_add32_ctrl #(
    parameter int NIB = 8
) (
    input  logic                clk,
    input  logic                reset,
    serial_add32_ctrl_if.slave  bus
);
    localparam int W     = 4 * NIB;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg,  state_next;
    logic [IDX_W-1:0]   idx_reg,    idx_next;
    logic               carry_reg,  carry_next;
    logic [W-1:0]       a_reg,      a_next;
    logic [W-1:0]       b_reg,      b_next;
    logic [W-1:0]       result_reg, result_next;
    logic               co_reg,     co_next;
    logic               ov_reg,     ov_next;

    // Operand nibble views, so the slice input is a plain indexed select.
    logic [3:0] a_nib [NIB];
    logic [3:0] b_nib [NIB];

    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*4 +: 4];
            assign b_nib[gi] = b_reg[gi*4 +: 4];
        end
    endgenerate

    logic [3:0] slice_x;
    logic [3:0] slice_y;
    logic [3:0] slice_s;
    logic       slice_co;
    logic       slice_c3;

    assign slice_x = a_nib[idx_reg];
    assign slice_y = b_nib[idx_reg];

    cla4_ov u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co),
        .c3 (slice_c3)
    );

    // Starts arriving while RUN is active are dropped entirely.
    logic start_ok;
    assign start_ok = bus.start && (state_reg != RUN);

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        carry_next  = carry_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        result_next = result_reg;
        co_next     = co_reg;
        ov_next     = ov_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start_ok) begin
                    a_next     = bus.a;
                    b_next     = bus.op ? ~bus.b : bus.b;
                    carry_next = bus.op;
                    idx_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                result_next[int'(idx_reg)*4 +: 4] = slice_s;
                carry_next = slice_co;
                if (idx_reg == IDX_LAST) begin
                    // Last nibble: its flags describe the whole word.
                    co_next    = slice_co;
                    ov_next    = slice_c3 ^ slice_co;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            carry_reg  <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            co_reg     <= 1'b0;
            ov_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            carry_reg  <= carry_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            result_reg <= result_next;
            co_reg     <= co_next;
            ov_reg     <= ov_next;
        end
    end

    assign bus.busy   = (state_reg == RUN);
    assign bus.done   = (state_reg == DONE);
    assign bus.result = result_reg;
    assign bus.co     = co_reg;
    assign bus.ov     = ov_reg;
    assign bus.zero   = (result_reg == '0);
endmodule

// File: tb/tb_serial_add32_ctrl.sv
// tb_serial_add32_ctrl
// Table of operand/expected records applied in a loop, plus hand-written
// sequences for start-in-RUN, start-in-DONE and reset-mid-RUN.  Expected
// results are pushed to a scoreboard queue when a start is driven and
// compared by a monitor whenever done is seen.
module tb_serial_add32_ctrl;
    localparam int NIB = 8;
    localparam int LAT = NIB + 1;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        zero;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    vec_t sb[$];
    vec_t vecs[12];

    serial_add32_ctrl_if #(.NIB(NIB)) bus_if ();

    serial_add32_ctrl #(.NIB(NIB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    // Independent reference: 33-bit arithmetic, overflow from operand signs.
    function automatic vec_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        logic [32:0] full;
        v.op = op;
        v.a  = a;
        v.b  = b;
        if (op) full = {1'b0, a} + {1'b0, ~b} + 33'd1;
        else    full = {1'b0, a} + {1'b0, b};
        v.res = full[31:0];
        v.co  = full[32];
        if (op) v.ov = (a[31] != b[31]) && (v.res[31] != a[31]);
        else    v.ov = (a[31] == b[31]) && (v.res[31] != a[31]);
        v.zero = (v.res == 32'd0);
        return v;
    endfunction

    function automatic vec_t mk(input logic op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic co, input logic ov,
                                input logic zero);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.co = co; v.ov = ov; v.zero = zero;
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus_if.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with no pending request");
            end else begin
                vec_t e;
                e = sb.pop_front();
                $display("[TB] done op=%0b a=%08h b=%08h result=%08h co=%0b ov=%0b zero=%0b",
                         e.op, e.a, e.b, bus_if.result, bus_if.co, bus_if.ov, bus_if.zero);
                check("result", 64'(bus_if.result), 64'(e.res));
                check("co", 64'(bus_if.co), 64'(e.co));
                check("ov", 64'(bus_if.ov), 64'(e.ov));
                check("zero", 64'(bus_if.zero), 64'(e.zero));
                check("busy_in_done", 64'(bus_if.busy), 64'd0);
            end
        end
    end

    // Called at a negedge: drive a start, push its expectation, drop start
    // just after the accepting edge.
    task automatic issue(input vec_t v);
        bus_if.start = 1'b1;
        bus_if.op    = v.op;
        bus_if.a     = v.a;
        bus_if.b     = v.b;
        sb.push_back(v);
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done is seen.
    task automatic wait_done(output int cnt, output logic busy_ok);
        cnt     = 0;
        busy_ok = 1'b1;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (bus_if.done === 1'b1) break;
            if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
        end
        if (bus_if.done !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", cnt);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
        check({tag, "_done"}, 64'(bus_if.done), 64'd0);
        check({tag, "_result"}, 64'(bus_if.result), 64'd0);
        check({tag, "_co"}, 64'(bus_if.co), 64'd0);
        check({tag, "_ov"}, 64'(bus_if.ov), 64'd0);
        check({tag, "_zero"}, 64'(bus_if.zero), 64'd1);
    endtask

    initial begin
        int   cnt;
        logic busy_ok;
        logic saw_done;
        vec_t v1;
        vec_t v2;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = mk(1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0);
        vecs[1] = mk(1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        vecs[2] = mk(1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        vecs[3] = mk(1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1);
        vecs[4] = mk(1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0, 1'b0);
        vecs[5] = mk(1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1);
        vecs[6] = mk(1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1);
        vecs[7] = mk(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0);
        vecs[8] = mk(1'b1, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        for (int i = 9; i < 12; i++)
            vecs[i] = model(1'($urandom_range(0, 1)), $urandom, $urandom);

        bus_if.start = 1'b0;
        bus_if.op    = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");

        // Deassert reset and request on the same negedge: the first edge
        // after reset falls must accept the start.
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i]);
            wait_done(cnt, busy_ok);
            check("latency", 64'(cnt), 64'(LAT));
            check("busy_run", 64'(busy_ok), 64'd1);
            @(negedge clk);
            check("done_pulse_1cyc", 64'(bus_if.done), 64'd0);
            check("idle_busy", 64'(bus_if.busy), 64'd0);
            check("result_held", 64'(bus_if.result), 64'(vecs[i].res));
        end

        // Start pulsed with other operands 3 cycles into RUN is ignored.
        v1 = model(1'b0, 32'h0000FFFF, 32'h00000001);
        issue(v1);
        cnt     = 0;
        busy_ok = 1'b1;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (cnt == 3) begin
                bus_if.start = 1'b1;
                bus_if.op    = 1'b1;
                bus_if.a     = 32'hCAFEF00D;
                bus_if.b     = 32'h12345678;
            end else if (cnt == 4) begin
                bus_if.start = 1'b0;
            end
            if (bus_if.done === 1'b1) break;
            if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
        end
        bus_if.start = 1'b0;
        check("ignored_start_latency", 64'(cnt), 64'(LAT));
        check("ignored_start_busy", 64'(busy_ok), 64'd1);
        @(negedge clk);
        check("ignored_start_idle", 64'(bus_if.busy), 64'd0);
        check("ignored_start_no_2nd", 64'(sb.size()), 64'd0);

        // Start asserted during the DONE cycle chains straight into RUN.
        v1 = model(1'b0, 32'h11111111, 32'h22222222);
        v2 = model(1'b1, 32'h00000010, 32'h00000020);
        issue(v1);
        wait_done(cnt, busy_ok);
        check("chain_first_latency", 64'(cnt), 64'(LAT));
        issue(v2);
        // 1 ns after the accepting edge: must already be in RUN, no IDLE gap.
        check("chain_busy_after_done", 64'(bus_if.busy), 64'd1);
        wait_done(cnt, busy_ok);
        check("chain_second_latency", 64'(cnt), 64'(LAT));
        check("chain_busy_run", 64'(busy_ok), 64'd1);
        @(negedge clk);

        // Reset mid-RUN aborts without a done pulse.
        v1 = model(1'b0, 32'hDEADBEEF, 32'h00000001);
        issue(v1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check_reset_vals("abort");
        reset    = 1'b0;
        saw_done = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        v1 = model(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(v1);
        wait_done(cnt, busy_ok);
        check("post_abort_latency", 64'(cnt), 64'(LAT));
        @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_add32_ctrl.md
SERIAL_ADD32_CTRL -- requirements
Module: serial_add32_ctrl

Interface
REQ-001 Parameter: NIB, default 8, number of 4-bit slices; operand/result width is 4*NIB bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled on each rising edge.
REQ-005 op  input  1  operation select: 0 = add (a+b), 1 = subtract (a-b).
REQ-006 a  input  4*NIB  operand A, sampled only when start is accepted.
REQ-007 b  input  4*NIB  operand B, sampled only when start is accepted.
REQ-008 busy  output  1  high while a computation is in progress.
REQ-009 done  output  1  one-cycle pulse marking result valid.
REQ-010 result  output  4*NIB  sum/difference, held stable from done until next accepted start.
REQ-011 co  output  1  carry out of MSB slice (subtract: 1 = no borrow).
REQ-012 ov  output  1  signed overflow: c3 XOR co of the MSB slice.
REQ-013 zero  output  1  high when result equals 0.

Function
REQ-014 Block SHALL instantiate exactly one cla4_ov slice and reuse it over NIB cycles, LSB nibble first.
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored with no effect on state or operands.
REQ-017 On acceptance: latch a; latch b when op=0 or ~b when op=1; carry register := op; nibble index := 0; next state RUN.
REQ-018 In RUN, each cycle SHALL feed nibble[index] of both latched operands and the carry register to the slice, write slice s into result nibble[index], store slice co into the carry register, increment index.
REQ-019 When index = NIB-1 in RUN, co and ov SHALL be captured from that slice and next state SHALL be DONE.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE unless a new start is accepted, in which case next state is RUN.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-022 Latency: start accepted at edge k -> done=1 in the cycle following edge k+NIB, i.e. NIB+1 cycles from start.
REQ-023 result, co, ov, zero SHALL be meaningful only when done=1 or after done in IDLE; partial nibbles MAY be visible in RUN.
REQ-024 Index counter SHALL be ceil(log2(NIB)) bits and SHALL not wrap past NIB-1.
REQ-025 Arithmetic is modulo 2^(4*NIB); no saturation.

Reset
REQ-026 reset=1 SHALL force state IDLE, index 0, carry 0, result 0, co 0, ov 0, busy 0, done 0; zero reads 1.
REQ-027 reset SHALL take priority over start and over any RUN/DONE activity, aborting an in-flight operation with no done pulse.
REQ-028 First start SHALL be accepted on the edge after reset deasserts.

Verification (NIB=8)
REQ-029 Add 0x7FFFFFFF + 0x00000001 -> done 9 cycles after start, result 0x80000000, co=0, ov=1, zero=0.
REQ-030 Sub 0x00000000 - 0x00000001 -> result 0xFFFFFFFF, co=0, ov=0; sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, co=1, ov=1.
REQ-031 Add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, co=1, ov=0, zero=1.
REQ-032 Start with new operands pulsed 3 cycles into RUN -> ignored; original result delivered on schedule, busy uninterrupted.
REQ-033 Start asserted in DONE cycle -> accepted; second done exactly 9 cycles later, no IDLE cycle between.
REQ-034 reset asserted mid-RUN -> next cycle all outputs at reset values, no done pulse; subsequent operation correct.
